// File: rtl/cm_ord_tree.sv
// cm_ord_tree: pipelined min/max comparison tree returning value and index.
// Optional CM_ORD_TREE_MASK_EN adds i_mask (per-element enable) and o_empty.
package cm_pkg;
  typedef enum logic [1:0] {
    ORD_MIN,
    ORD_MAX,
    ORD_SORT
  } ord_e;
endpackage

module cm_ord_tree
  import cm_pkg::*;
#(
  parameter int   N          = 8,
  parameter int   W          = 16,
  parameter ord_e ORD        = ORD_MIN,
  parameter int   REG_STAGES = 1,
  localparam int  S          = $clog2(N),
  localparam int  IW         = (S < 1) ? 1 : S
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_vld,
  output logic           o_rdy,
  input  logic [N*W-1:0] i_data,
  output logic           o_vld,
  input  logic           i_rdy,
  output logic [W-1:0]   o_data,
  output logic [IW-1:0]  o_idx
`ifdef CM_ORD_TREE_MASK_EN
  ,
  input  logic [N-1:0]   i_mask,
  output logic           o_empty
`endif
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("cm_ord_tree: N=%0d outside 2..256", N);
  end
  if (ORD != ORD_MIN && ORD != ORD_MAX) begin : g_bad_ord
    $error("cm_ord_tree: ORD must be ORD_MIN or ORD_MAX");
  end
  if (REG_STAGES < 0 || REG_STAGES > S) begin : g_bad_reg
    $error("cm_ord_tree: REG_STAGES=%0d outside 0..%0d",
           REG_STAGES, S);
  end

  function automatic int cnt(input int s);
    return (N + (1 << s) - 1) >> s;
  endfunction

  function automatic bit is_reg(input int s);
    return ((s * REG_STAGES) / S) != (((s - 1) * REG_STAGES) / S);
  endfunction

  logic [W-1:0]  val [S+1][N];
  logic [IW-1:0] idx [S+1][N];
  logic          msk [S+1][N];
  logic          vld [S+1];
  logic          en;

  // Masked leaves carry 0 so an all-masked vector reduces to value 0, index 0.
  for (genvar k = 0; k < N; k++) begin : g_leaf
`ifdef CM_ORD_TREE_MASK_EN
    assign msk[0][k] = i_mask[k];
    assign val[0][k] = i_mask[k] ? i_data[k*W +: W] : '0;
`else
    assign msk[0][k] = 1'b1;
    assign val[0][k] = i_data[k*W +: W];
`endif
    assign idx[0][k] = IW'(k);
  end
  assign vld[0] = i_vld;

  for (genvar s = 1; s <= S; s++) begin : g_lvl
    localparam int CP = cnt(s - 1);
    localparam int C  = cnt(s);
    logic [W-1:0]  cv [C];
    logic [IW-1:0] ci [C];
    logic          cm [C];

    for (genvar j = 0; j < C; j++) begin : g_node
      if (2 * j + 1 < CP) begin : g_cmp
        logic better;
        logic pick;
        // Right child wins only when strictly better: ties keep lower index.
        assign better = (ORD == ORD_MAX)
          ? (val[s-1][2*j+1] > val[s-1][2*j])
          : (val[s-1][2*j+1] < val[s-1][2*j]);
        assign pick = msk[s-1][2*j+1]
                   && (!msk[s-1][2*j] || better);
        assign cv[j] = pick ? val[s-1][2*j+1] : val[s-1][2*j];
        assign ci[j] = pick ? idx[s-1][2*j+1] : idx[s-1][2*j];
        assign cm[j] = msk[s-1][2*j] | msk[s-1][2*j+1];
      end else begin : g_pass
        assign cv[j] = val[s-1][2*j];
        assign ci[j] = idx[s-1][2*j];
        assign cm[j] = msk[s-1][2*j];
      end
    end

    for (genvar j = C; j < N; j++) begin : g_pad
      assign val[s][j] = '0;
      assign idx[s][j] = '0;
      assign msk[s][j] = 1'b0;
    end

    if (is_reg(s)) begin : g_reg
      logic          rv;
      logic [W-1:0]  nv [C];
      logic [IW-1:0] ni [C];
      logic          nm [C];
      always_ff @(posedge clk) begin
        if (rst) begin
          rv <= 1'b0;
          nv <= '{default: '0};
          ni <= '{default: '0};
          nm <= '{default: 1'b1};
        end else if (en) begin
          rv <= vld[s-1];
          nv <= cv;
          ni <= ci;
          nm <= cm;
        end
      end
      assign vld[s] = rv;
      for (genvar j = 0; j < C; j++) begin : g_out
        assign val[s][j] = nv[j];
        assign idx[s][j] = ni[j];
        assign msk[s][j] = nm[j];
      end
    end else begin : g_comb
      assign vld[s] = vld[s-1];
      for (genvar j = 0; j < C; j++) begin : g_out
        assign val[s][j] = cv[j];
        assign idx[s][j] = ci[j];
        assign msk[s][j] = cm[j];
      end
    end
  end

  assign en     = i_rdy || !o_vld;
  assign o_rdy  = (REG_STAGES == 0) ? i_rdy : en;
  assign o_vld  = vld[S];
  assign o_data = val[S][0];
  assign o_idx  = idx[S][0];
`ifdef CM_ORD_TREE_MASK_EN
  assign o_empty = !msk[S][0];
`endif

endmodule

// File: tb/tb_cm_ord_tree.sv
// tb_cm_ord_tree: vector table, hand sequences and random scoreboard
// against a reference selector for several cm_ord_tree configurations.
module tb_cm_ord_tree;
  import cm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: N=8 MIN REG=1
  logic v0 = 0, ir0 = 1, o_rdy0, o_vld0;
  logic [127:0] d0 = '0;
  logic [15:0] o_data0;
  logic [2:0] o_idx0;
  // dut1: N=5 MAX REG=0
  logic v1 = 0, ir1 = 1, o_rdy1, o_vld1;
  logic [79:0] d1 = '0;
  logic [15:0] o_data1;
  logic [2:0] o_idx1;
  // dut2: N=8 MIN REG=3
  logic v2 = 0, ir2 = 1, o_rdy2, o_vld2;
  logic [127:0] d2 = '0;
  logic [15:0] o_data2;
  logic [2:0] o_idx2;
`ifdef CM_ORD_TREE_MASK_EN
  logic e0, e1, e2;
  logic v4 = 0, ir4 = 1, o_rdy4, o_vld4, o_empty4;
  logic [63:0] d4 = '0;
  logic [3:0] m4 = '0;
  logic [15:0] o_data4;
  logic [1:0] o_idx4;
`endif

  cm_ord_tree #(.N(8), .W(16), .ORD(ORD_MIN), .REG_STAGES(1)) dut0 (
    .clk(clk), .rst(rst), .i_vld(v0), .o_rdy(o_rdy0), .i_data(d0),
    .o_vld(o_vld0), .i_rdy(ir0), .o_data(o_data0), .o_idx(o_idx0)
`ifdef CM_ORD_TREE_MASK_EN
    , .i_mask(8'hFF), .o_empty(e0)
`endif
  );

  cm_ord_tree #(.N(5), .W(16), .ORD(ORD_MAX), .REG_STAGES(0)) dut1 (
    .clk(clk), .rst(rst), .i_vld(v1), .o_rdy(o_rdy1), .i_data(d1),
    .o_vld(o_vld1), .i_rdy(ir1), .o_data(o_data1), .o_idx(o_idx1)
`ifdef CM_ORD_TREE_MASK_EN
    , .i_mask(5'h1F), .o_empty(e1)
`endif
  );

  cm_ord_tree #(.N(8), .W(16), .ORD(ORD_MIN), .REG_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .i_vld(v2), .o_rdy(o_rdy2), .i_data(d2),
    .o_vld(o_vld2), .i_rdy(ir2), .o_data(o_data2), .o_idx(o_idx2)
`ifdef CM_ORD_TREE_MASK_EN
    , .i_mask(8'hFF), .o_empty(e2)
`endif
  );

`ifdef CM_ORD_TREE_MASK_EN
  cm_ord_tree #(.N(4), .W(16), .ORD(ORD_MIN), .REG_STAGES(1)) dut4 (
    .clk(clk), .rst(rst), .i_vld(v4), .o_rdy(o_rdy4), .i_data(d4),
    .o_vld(o_vld4), .i_rdy(ir4), .o_data(o_data4), .o_idx(o_idx4),
    .i_mask(m4), .o_empty(o_empty4)
  );
`endif

  typedef struct packed {
    logic         dut;
    logic [127:0] e;
    logic [15:0]  v;
    logic [2:0]   i;
  } vec_t;

  typedef struct packed {
    logic [15:0] v;
    logic [2:0]  i;
  } res_t;

  vec_t tbl [11];
  res_t sb [$];
  bit   hold = 0;
  logic [15:0] hold_d;
  logic [2:0]  hold_i;
  int   n_out = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int a0, input int a1,
    input int a2, input int a3, input int a4, input int a5,
    input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4),
            16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Reference: linear scan keeping the first strictly better element.
  task automatic ref_sel(input logic [127:0] d, input int n,
    input bit mx, input logic [7:0] m, output logic [15:0] v,
    output int i, output bit empty);
    bit f;
    logic [15:0] e;
    f = 0; v = '0; i = 0;
    for (int k = 0; k < n; k++) begin
      e = d[k*16 +: 16];
      if (m[k] && (!f || (mx ? (e > v) : (e < v)))) begin
        f = 1; v = e; i = k;
      end
    end
    empty = !f;
  endtask

  function automatic logic [15:0] rnd_e();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [127:0] rnd_vec();
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = rnd_e();
    return r;
  endfunction

  // One dut2 cycle: drive, check handshake and scoreboard, record accept.
  task automatic step2(input bit v, input logic [127:0] d,
                       input bit ir, output bit acc);
    res_t exp;
    logic [15:0] rv;
    int ri;
    bit re;
    @(negedge clk);
    v2 = v; d2 = d; ir2 = ir;
    #1;
    chk("rdy_rule", o_rdy2, ir || !o_vld2);
    if (hold) begin
      chk("stall_vld", o_vld2, 1);
      chk("stall_data", o_data2, hold_d);
      chk("stall_idx", o_idx2, hold_i);
    end
    if (o_vld2 && ir) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out actual=%0d required=none", o_data2);
      end else begin
        exp = sb.pop_front();
        chk("sb_data", o_data2, exp.v);
        chk("sb_idx", o_idx2, exp.i);
      end
    end
    acc = v && o_rdy2;
    if (acc) begin
      ref_sel(d, 8, 0, 8'hFF, rv, ri, re);
      sb.push_back({rv, 3'(ri)});
    end
    hold = o_vld2 && !ir;
    hold_d = o_data2;
    hold_i = o_idx2;
  endtask

  initial begin
    bit acc;
    int lat, sent, base;
    logic [15:0] rv;
    int ri;
    bit re;
    logic [127:0] t128;
    logic [127:0] vq [10];

    tbl[0]  = '{0, mk(7,3,9,3,12,40,5,3), 16'd3, 3'd1};
    tbl[1]  = '{0, mk(5,5,5,5,5,5,5,5), 16'd5, 3'd0};
    tbl[2]  = '{0, mk(65535,65535,65535,65535,65535,65535,65535,0),
                16'd0, 3'd7};
    tbl[3]  = '{0, mk(65535,65535,65535,65535,65535,65535,65535,65535),
                16'd65535, 3'd0};
    tbl[4]  = '{0, mk(100,90,80,70,60,50,40,30), 16'd30, 3'd7};
    tbl[5]  = '{0, mk(8,0,6,0,4,3,2,1), 16'd0, 3'd1};
    tbl[6]  = '{1, mk(1,2,3,4,65535,0,0,0), 16'd65535, 3'd4};
    tbl[7]  = '{1, mk(7,7,7,7,7,0,0,0), 16'd7, 3'd0};
    tbl[8]  = '{1, mk(0,65535,65535,3,0,0,0,0), 16'd65535, 3'd1};
    tbl[9]  = '{1, mk(9,8,7,6,10,0,0,0), 16'd10, 3'd4};
    tbl[10] = '{1, mk(32767,40000,32768,0,1,0,0,0), 16'd40000, 3'd1};

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_vld0", o_vld0, 0);
    chk("rst_data0", o_data0, 0);
    chk("rst_idx0", o_idx0, 0);
    chk("rst_rdy0", o_rdy0, 1);
    chk("rst_vld2", o_vld2, 0);
    chk("rst_rdy2", o_rdy2, 1);

    for (int t = 0; t < 11; t++) begin
      if (!tbl[t].dut) begin
        @(negedge clk);
        v0 = 1; d0 = tbl[t].e;
        #1 chk("tbl_rdy0", o_rdy0, 1);
        @(negedge clk);
        v0 = 0;
        #1;
        chk("tbl_vld0", o_vld0, 1);
        chk("tbl_data0", o_data0, tbl[t].v);
        chk("tbl_idx0", o_idx0, tbl[t].i);
      end else begin
        @(negedge clk);
        t128 = tbl[t].e;
        v1 = 1; ir1 = 1; d1 = t128[79:0];
        #1;
        chk("tbl_vld1", o_vld1, 1);
        chk("tbl_rdy1", o_rdy1, 1);
        chk("tbl_data1", o_data1, tbl[t].v);
        chk("tbl_idx1", o_idx1, tbl[t].i);
      end
    end

    // Combinational path: ready follows downstream ready.
    @(negedge clk);
    ir1 = 0;
    #1 chk("comb_rdy_low", o_rdy1, 0);
    ir1 = 1;
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      t128 = rnd_vec();
      d1 = t128[79:0];
      #1;
      ref_sel(t128, 5, 1, 8'hFF, rv, ri, re);
      chk("rnd1_data", o_data1, rv);
      chk("rnd1_idx", o_idx1, ri);
    end
    v1 = 0;

    // Latency of the 3-stage pipe.
    step2(1, mk(4,9,2,2,7,1,1,3), 1, acc);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step2(0, '0, 1, acc);
      if (o_vld2) lat = c;
    end
    chk("latency", lat, 3);

    // Back-to-back stream with a three-cycle downstream stall.
    for (int k = 0; k < 10; k++) vq[k] = rnd_vec();
    sent = 0;
    base = n_out;
    for (int cyc = 0; cyc < 60 && (sent < 10 || sb.size() > 0); cyc++)
    begin
      step2(sent < 10, vq[sent < 10 ? sent : 0],
            !(cyc >= 4 && cyc <= 6), acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 10);
    chk("bp_count", n_out - base, 10);

    // Random valid/ready traffic.
    for (int r = 0; r < 300; r++)
      step2($urandom_range(0, 3) != 0, rnd_vec(),
            $urandom_range(0, 3) != 0, acc);
    for (int c = 0; c < 20 && sb.size() > 0; c++)
      step2(0, '0, 1, acc);
    chk("drain_empty", sb.size(), 0);

    // Reset with two vectors in flight.
    step2(1, mk(9,8,7,6,5,4,3,2), 1, acc);
    step2(1, mk(6,6,6,6,6,6,6,6), 1, acc);
    @(negedge clk);
    rst = 1; v2 = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_vld", o_vld2, 0);
    chk("mid_rst_data", o_data2, 0);
    chk("mid_rst_idx", o_idx2, 0);
    chk("mid_rst_rdy", o_rdy2, 1);
    sb.delete();
    hold = 0;
    for (int c = 0; c < 6; c++) step2(0, '0, 1, acc);

`ifdef CM_ORD_TREE_MASK_EN
    @(negedge clk);
    t128 = mk(0,5,2,8,0,0,0,0);
    v4 = 1; d4 = t128[63:0]; m4 = 4'b1010;
    @(negedge clk);
    m4 = 4'b0000;
    #1;
    chk("mask_vld", o_vld4, 1);
    chk("mask_data", o_data4, 5);
    chk("mask_idx", o_idx4, 1);
    chk("mask_empty", o_empty4, 0);
    @(negedge clk);
    v4 = 0;
    #1;
    chk("empty_vld", o_vld4, 1);
    chk("empty_flag", o_empty4, 1);
    chk("empty_data", o_data4, 0);
    chk("empty_idx", o_idx4, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
